pio_spi_host: RTL

- SPI mode-0 slave front-end that drives the PIO block's host command interface: `action`, `index`, `mindex` and `din` are outputs here, and `dout` is an input.
- Lets an external MCU load instructions, configure machines, push and pull FIFO words, and issue immediate instructions over 4 wires.
- Sits between the top-level SPI pins and the pio instance. Runs entirely in the `clk` domain with oversampled SPI signals.

---
 rtl/pio_spi_host.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pio_spi_host.sv
// SPI mode-0 slave that turns 48-bit MCU frames into single-cycle PIO host commands.
// Pull results are captured RD_LAT cycles after the strobe and returned on the next frame.
module pio_spi_host #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic [4:0]  index,
    output logic [31:0] din,
    input  logic [31:0] dout,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned FRAME_BITS = 48;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned RD_W       = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_q;
    logic                   cs_q;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [47:0]      rx;
    logic [46:0]      tx;
    logic [31:0]      rdback;
    logic [RD_W-1:0]  rd_cnt;

    logic sck_s_c;
    logic cs_s_c;
    logic mosi_s_c;
    logic sck_rise_c;
    logic sck_fall_c;
    logic cs_rise_c;
    logic cs_fall_c;
    logic abort_c;

    assign sck_s_c    = sck_sync[SYNC_STAGES-1];
    assign cs_s_c     = cs_sync[SYNC_STAGES-1];
    assign mosi_s_c   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise_c = sck_s_c & ~sck_q;
    assign sck_fall_c = ~sck_s_c & sck_q;
    assign cs_rise_c  = cs_s_c & ~cs_q;
    assign cs_fall_c  = ~cs_s_c & cs_q;

    // Sync chains reset low so a CS still held low after reset never looks like a new fall
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sck_sync[0]  <= spi_sck;
            cs_sync[0]   <= spi_cs_n;
            mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_q <= sck_s_c;
            cs_q  <= cs_s_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // The 48th rise wins over a simultaneous CS rise, so the frame still issues
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_fall_c) begin
                    state_nxt = S_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (sck_rise_c && cnt != CNT_W'(FRAME_BITS)) cnt_nxt = cnt + CNT_W'(1);
                if (cnt_nxt == CNT_W'(FRAME_BITS)) begin
                    state_nxt = S_ISSUE;
                end else if (cs_rise_c) begin
                    state_nxt = S_IDLE;
                    abort_c   = 1'b1;
                end
            end
            S_ISSUE: state_nxt = S_DONE;
            S_DONE:  if (cs_s_c) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            rdback    <= '0;
            rd_cnt    <= '0;
            action    <= '0;
            mindex    <= '0;
            index     <= '0;
            din       <= '0;
            spi_miso  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            action    <= '0;
            frame_err <= abort_c;
            spi_miso  <= 1'b0;

            if (rd_cnt != '0) begin
                rd_cnt <= rd_cnt - RD_W'(1);
                if (rd_cnt == RD_W'(1)) rdback <= dout;
            end

            if (state == S_SHIFT && sck_rise_c) rx <= {rx[46:0], mosi_s_c};

            case (state)
                S_IDLE: begin
                    if (cs_fall_c) begin
                        // Bit 0 is always zero; tx holds bits 1..47
                        tx   <= {15'h0000, rdback};
                        busy <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort_c) begin
                        busy <= 1'b0;
                    end else if (sck_fall_c) begin
                        spi_miso <= tx[46];
                        tx       <= {tx[45:0], 1'b0};
                    end else begin
                        spi_miso <= spi_miso;
                    end
                end
                S_ISSUE: begin
                    action <= rx[47:44];
                    mindex <= rx[43:42];
                    index  <= rx[36:32];
                    din    <= rx[31:0];
                    busy   <= 1'b0;
                    if (rx[47:44] == 4'd3) rd_cnt <= RD_W'(RD_LAT);
                end
                default: ;
            endcase
        end
    end

endmodule
